vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

VGA raster timing generator for the 640x480 @ 60 Hz display path, clocked directly by the 25 MHz pixel clock from the upstream clock divider. It keeps horizontal and vertical position counters and produces registered, mutually aligned hsync/vsync, visible-area flag, pixel coordinates, and line/frame start strobes. The downstream pixel/color logic consumes these outputs.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- clk  in  1  25 MHz pixel clock from the clock divider
- reset  in  1  asynchronous, active-low reset (0 = reset)
- en  in  1  advance enable; when 0 all state holds
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- video_on  out  1  high while (pixel_x, pixel_y) is inside the visible area
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1
- line_start  out  1  one-cycle strobe on entry to pixel_x = 0
- frame_start  out  1  one-cycle strobe on entry to (0,0)

## Operation
- H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525). All counters 10 bits; parameters must keep totals ≤ 1024.
- Horizontal counter h: when en=1, increments each clk; at H_TOTAL-1 wraps to 0.
- Vertical counter v: increments only on the cycle h wraps; at V_TOTAL-1 (with h wrapping) wraps to 0.
- pixel_x = h, pixel_y = v (the counter registers themselves).
- hsync_n = 0 iff H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC (656..751).
- vsync_n = 0 iff V_VISIBLE+V_FRONT ≤ v < V_VISIBLE+V_FRONT+V_SYNC (490..491).
- video_on = 1 iff h < H_VISIBLE and v < V_VISIBLE.
- hsync_n, vsync_n and video_on are registered, computed from the next-state counter values, so in every cycle they correspond exactly to the pixel_x/pixel_y presented in that same cycle (no skew, no combinational paths to outputs).
- line_start = 1 for exactly one cycle when h transitions 799→0 with en=1; frame_start = 1 for one cycle when (h,v) transitions (799,524)→(0,0) with en=1. Strobes never assert while en=0 or out of reset.
- en=0: counters, syncs and video_on hold; strobes forced 0. Resuming en=1 continues from the held position.

## Timing
- Reset (reset=0, asynchronous): pixel_x=0, pixel_y=0, hsync_n=1, vsync_n=1, video_on=1, line_start=0, frame_start=0.
- Reset release: first en=1 rising edge moves to (1,0); reset asserted mid-frame returns all outputs to reset values immediately, independent of clk.
- Latency: zero cycles between a counter value and its derived flags (same cycle).
- Line period 800 clk; frame period 420000 clk (16.8 ms at 25 MHz, ~59.5 Hz).
- Simultaneous h and v wrap: line_start and frame_start both assert in the same cycle.
- hsync_n low for exactly 96 consecutive clk per line; vsync_n low for exactly 1600 consecutive clk per frame, starting at h=0 of line 490.

## Test plan
- Reset: hold reset=0, toggle clk → all outputs at reset values; release with en=1, 1 edge → pixel_x=1, pixel_y=0, video_on=1.
- Horizontal line: run 800 edges from (0,0) → hsync_n low exactly on pixel_x 656..751, video_on low on 640..799, line_start high once at return to pixel_x=0, pixel_y=1.
- Full frame: run 420000 edges → vsync_n low exactly for pixel_y 490..491 (1600 clk), video_on never high for pixel_y ≥ 480, frame_start high once, coinciding with line_start, at (0,0).
- Enable hold: deassert en at (700,100) for 50 clk → outputs frozen at (700,100) with hsync_n=0, no strobes; reassert → next edge gives (701,100).
- Async reset mid-frame: assert reset=0 between edges at (300,250) → outputs return to reset values without a clk edge; release → counting restarts from (0,0), no frame_start until next full frame.
- Sync alignment check: every cycle compare hsync_n/vsync_n/video_on against formula applied to same-cycle pixel_x/pixel_y → zero mismatches over two frames.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: horizontal/vertical position counters with registered,
// same-cycle-aligned sync, visible-area flag and line/frame start strobes.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] r_h, r_v;
  logic       r_hsync_n, r_vsync_n, r_video_on, r_line_start, r_frame_start;

  logic [9:0] w_h_next, w_v_next;
  logic       w_h_last, w_v_last;
  logic       w_hsync_n_next, w_vsync_n_next, w_video_on_next;

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_h_next = r_h;
    w_v_next = r_v;
    if (en) begin
      if (w_h_last) begin
        w_h_next = '0;
        w_v_next = w_v_last ? '0 : r_v + 10'd1;
      end else begin
        w_h_next = r_h + 10'd1;
      end
    end
  end

  // Flags are derived from the next-state position so that, once registered, they line
  // up exactly with the pixel_x/pixel_y registered on the same edge.
  assign w_hsync_n_next  = !((w_h_next >= HS_START) && (w_h_next < HS_END));
  assign w_vsync_n_next  = !((w_v_next >= VS_START) && (w_v_next < VS_END));
  assign w_video_on_next = (w_h_next < H_VIS_END) && (w_v_next < V_VIS_END);

  // NOTE: state registers use non-blocking assignments so all of them sample the
  // pre-edge values together; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h           <= '0;
      r_v           <= '0;
      r_hsync_n     <= 1'b1;
      r_vsync_n     <= 1'b1;
      r_video_on    <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_h           <= w_h_next;
      r_v           <= w_v_next;
      r_hsync_n     <= w_hsync_n_next;
      r_vsync_n     <= w_vsync_n_next;
      r_video_on    <= w_video_on_next;
      r_line_start  <= en && w_h_last;
      r_frame_start <= en && w_h_last && w_v_last;
    end
  end

  assign pixel_x     = r_h;
  assign pixel_y     = r_v;
  assign hsync_n     = r_hsync_n;
  assign vsync_n     = r_vsync_n;
  assign video_on    = r_video_on;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size 640x480 instance and a shrunken-timing instance
// run side by side against an arithmetic raster model, plus directed boundary checks.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
  } out_t;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb;
  } timing_t;

  localparam int SH_VIS = 16, SH_FP = 4, SH_SY = 6, SH_BP = 6;
  localparam int SV_VIS = 12, SV_FP = 3, SV_SY = 2, SV_BP = 4;
  localparam int S_HT   = SH_VIS + SH_FP + SH_SY + SH_BP;   // 32
  localparam int S_VT   = SV_VIS + SV_FP + SV_SY + SV_BP;   // 21
  localparam int S_FRAME = S_HT * S_VT;                     // 672

  timing_t p_full  = '{640, 16, 96, 48, 480, 10, 2, 33};
  timing_t p_small = '{SH_VIS, SH_FP, SH_SY, SH_BP, SV_VIS, SV_FP, SV_SY, SV_BP};

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic       f_hs, f_vs, f_von, f_ls, f_fs;
  logic [9:0] f_x, f_y;
  logic       s_hs, s_vs, s_von, s_ls, s_fs;
  logic [9:0] s_x, s_y;

  out_t obs_full, obs_small;
  assign obs_full  = '{hs: f_hs, vs: f_vs, von: f_von, x: f_x, y: f_y, ls: f_ls, fs: f_fs};
  assign obs_small = '{hs: s_hs, vs: s_vs, von: s_von, x: s_x, y: s_y, ls: s_ls, fs: s_fs};

  int checks = 0;
  int passed = 0;
  int t_full = 0;
  int t_small = 0;
  bit stepped = 1'b0;

  always #5 clk = ~clk;

  vga_sync_gen u_full (
    .clk(clk), .reset(rst_n), .en(en),
    .hsync_n(f_hs), .vsync_n(f_vs), .video_on(f_von),
    .pixel_x(f_x), .pixel_y(f_y),
    .line_start(f_ls), .frame_start(f_fs)
  );

  vga_sync_gen #(
    .H_VISIBLE(SH_VIS), .H_FRONT(SH_FP), .H_SYNC(SH_SY), .H_BACK(SH_BP),
    .V_VISIBLE(SV_VIS), .V_FRONT(SV_FP), .V_SYNC(SV_SY), .V_BACK(SV_BP)
  ) u_small (
    .clk(clk), .reset(rst_n), .en(en),
    .hsync_n(s_hs), .vsync_n(s_vs), .video_on(s_von),
    .pixel_x(s_x), .pixel_y(s_y),
    .line_start(s_ls), .frame_start(s_fs)
  );

  function automatic int frame_len(timing_t p);
    return (p.hv + p.hf + p.hs + p.hb) * (p.vv + p.vf + p.vs + p.vb);
  endfunction

  // Raster position is simply the count of enabled edges since reset, folded by the
  // line and frame lengths; every output follows from that position.
  function automatic out_t model(timing_t p, int t, bit adv);
    int ht, vt, h, v;
    out_t o;
    ht    = p.hv + p.hf + p.hs + p.hb;
    vt    = p.vv + p.vf + p.vs + p.vb;
    h     = t % ht;
    v     = (t / ht) % vt;
    o.x   = 10'(h);
    o.y   = 10'(v);
    o.hs  = !((h >= p.hv + p.hf) && (h < p.hv + p.hf + p.hs));
    o.vs  = !((v >= p.vv + p.vf) && (v < p.vv + p.vf + p.vs));
    o.von = (h < p.hv) && (v < p.vv);
    o.ls  = adv && (h == 0);
    o.fs  = adv && (h == 0) && (v == 0);
    return o;
  endfunction

  task automatic check_out(input string tag, input out_t obs, input out_t exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b, expected x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b",
                tag, obs.x, obs.y, obs.hs, obs.vs, obs.von, obs.ls, obs.fs,
                exp.x, exp.y, exp.hs, exp.vs, exp.von, exp.ls, exp.fs);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic check_both();
    check_out($sformatf("full t=%0d", t_full), obs_full, model(p_full, t_full, stepped));
    check_out($sformatf("small t=%0d", t_small), obs_small, model(p_small, t_small, stepped));
  endtask

  task automatic step(input bit en_v);
    en = en_v;
    @(posedge clk);
    #1;
    stepped = rst_n && en_v;
    if (stepped) begin
      t_full  = (t_full + 1) % frame_len(p_full);
      t_small = (t_small + 1) % frame_len(p_small);
    end
    if (!rst_n) begin
      t_full  = 0;
      t_small = 0;
    end
    check_both();
  endtask

  task automatic run_until_small(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (t_small != target && n < budget) begin
      step(1'b1);
      n++;
    end
    check_int(tag, t_small, target);
  endtask

  initial begin
    int hs_low, von_low, ls_cnt, vs_low, fs_cnt, fs_coinc;
    rst_n = 1'b0;
    en    = 1'b1;

    // Reset held across several clock edges
    repeat (3) step(1'b1);
    check_int("reset video_on", int'(f_von), 1);

    // Release: first enabled edge lands on (1,0)
    rst_n = 1'b1;
    step(1'b1);
    check_int("first edge pixel_x", int'(f_x), 1);
    check_int("first edge pixel_y", int'(f_y), 0);

    // One full-size line: count sync, blanking and line strobes over states t=1..800
    hs_low = 0; von_low = 0; ls_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) step(1'b1);
      if (!f_hs)  hs_low++;
      if (!f_von) von_low++;
      if (f_ls)   ls_cnt++;
    end
    check_int("line hsync low count", hs_low, 96);
    check_int("line blank count", von_low, 160);
    check_int("line_start count", ls_cnt, 1);
    check_int("line wrap pixel_x", int'(f_x), 0);
    check_int("line wrap pixel_y", int'(f_y), 1);

    // Two shrunken frames: vsync width and frame strobes
    vs_low = 0; fs_cnt = 0; fs_coinc = 0;
    for (int i = 0; i < 2 * S_FRAME; i++) begin
      step(1'b1);
      if (!s_vs) vs_low++;
      if (s_fs) begin
        fs_cnt++;
        if (s_ls && s_x == 10'd0 && s_y == 10'd0) fs_coinc++;
      end
    end
    check_int("small vsync low count", vs_low, 2 * SV_SY * S_HT);
    check_int("small frame_start count", fs_cnt, 2);
    check_int("small frame_start aligned", fs_coinc, 2);

    // Enable hold inside the horizontal sync pulse at (22,5)
    run_until_small(5 * S_HT + 22, 2 * S_FRAME, "reach hold point");
    for (int i = 0; i < 50; i++) begin
      step(1'b0);
      check_int("hold hsync_n", int'(s_hs), 0);
    end
    step(1'b1);
    check_int("resume pixel_x", int'(s_x), 23);
    check_int("resume pixel_y", int'(s_y), 5);

    // Random enable pattern
    for (int i = 0; i < 600; i++) step(1'($urandom_range(0, 1)));

    // Asynchronous reset between edges at (10,8)
    run_until_small(8 * S_HT + 10, 2 * S_FRAME, "reach reset point");
    #2;
    rst_n = 1'b0;
    #1;
    t_full  = 0;
    t_small = 0;
    stepped = 1'b0;
    check_both();
    check_int("async reset pixel_x", int'(s_x), 0);
    check_int("async reset hsync_n", int'(f_hs), 1);
    repeat (2) step(1'b1);

    // Restart: no frame strobe until a whole frame has elapsed
    rst_n = 1'b1;
    fs_cnt = 0;
    for (int i = 0; i < S_FRAME - 1; i++) begin
      step(1'b1);
      if (s_fs) fs_cnt++;
    end
    check_int("no early frame_start", fs_cnt, 0);
    step(1'b1);
    check_int("frame_start after restart", int'(s_fs), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
